io_bridge: RTL and testbench



---
 rtl/io_bridge.sv | 230 +++++++++++++++++++++++
 tb/tb_io_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// -----------------------------------------------------------------------------
// io_bridge
//
// Bridges core load/store IO requests onto the simulation IO device port.
// Requests are queued in a small in-order FIFO. Each head entry is address
// screened: legal entries become one sysbus transaction using the device's
// level handshake (valid held until ready, then ready allowed to fall). Illegal
// entries are answered with an error response and never reach the bus. Every
// accepted request produces exactly one response, in order.
//
// Parameters
//   DEPTH    request FIFO entries (power of two, >= 2)
//   TIMEOUT  cycles to wait for device ready before aborting
//            (used only when IO_BRIDGE_TIMEOUT_EN is defined)
//
// Build option
//   IO_BRIDGE_TIMEOUT_EN  enables the REQ-state abort counter. When undefined
//                         the bridge waits for ready indefinitely.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   core_io_req_*            core request (valid/ready, write, addr, wdata)
//   core_io_resp_*           one-cycle response pulse with data and error flag
//   sysbus_o_io_*            transaction toward the device (valid/write/addr/data)
//   sysbus_i_io_*            device completion (ready) and read data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module io_bridge #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_io_req_valid,
    output logic        core_io_req_ready,
    input  logic        core_io_req_write,
    input  logic [31:0] core_io_req_addr,
    input  logic [31:0] core_io_req_wdata,
    output logic        core_io_resp_valid,
    output logic [31:0] core_io_resp_data,
    output logic        core_io_resp_err,
    output logic        sysbus_o_io_valid,
    output logic        sysbus_o_io_write,
    output logic [31:0] sysbus_o_io_addr,
    output logic [31:0] sysbus_o_io_data,
    input  logic        sysbus_i_io_ready,
    input  logic [31:0] sysbus_i_io_data
);

    localparam int unsigned     PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // FIFO
    req_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             push;
    logic             pop;
    req_t             head;
    logic             head_legal;

    // Control and registered outputs
    state_e           state_q, state_d;
    logic             bus_valid_q,  bus_valid_d;
    logic             bus_write_q,  bus_write_d;
    logic [31:0]      bus_addr_q,   bus_addr_d;
    logic [31:0]      bus_data_q,   bus_data_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q,  resp_data_d;
    logic             resp_err_q,   resp_err_d;

`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
    logic [31:0]      tmo_cnt_q, tmo_cnt_d;
`endif

    // Ready looks only at the registered occupancy: a full FIFO refuses a
    // request even on the edge where the head is being popped.
    assign core_io_req_ready = rst_n && (count_q != CNT_FULL);
    assign push              = core_io_req_valid && core_io_req_ready;

    assign head       = fifo_mem[rd_ptr_q];
    assign head_legal = (head.addr[31:24] == 8'hfe) && (head.addr[1:0] == 2'b00);

    assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

    // NOTE: entry storage carries no reset; count_q qualifies every read of
    // the head, so stale contents after reset are never acted on.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{write: core_io_req_write,
                                    addr:  core_io_req_addr,
                                    wdata: core_io_req_wdata};
        end
    end

    always_comb begin
        // NOTE: every next-state value is given its hold value before the case,
        // so no branch can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        pop          = 1'b0;
        bus_valid_d  = bus_valid_q;
        bus_write_d  = bus_write_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
`ifdef IO_BRIDGE_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (head_legal) begin
                        bus_valid_d = 1'b1;
                        bus_write_d = head.write;
                        bus_addr_d  = head.addr;
                        bus_data_d  = head.wdata;
                        state_d     = ST_REQ;
`ifdef IO_BRIDGE_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end else begin
                        // Screened out: answer immediately, bus untouched.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end
                end
            end

            ST_REQ: begin
                if (sysbus_i_io_ready) begin
                    bus_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = bus_write_q ? 32'h0 : sysbus_i_io_data;
                    state_d      = ST_DRAIN;
                end
`ifdef IO_BRIDGE_TIMEOUT_EN
                // A same-cycle ready above wins over the abort.
                else if (tmo_cnt_q == TMO_LAST) begin
                    bus_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                    state_d      = ST_DRAIN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
`endif
            end

            ST_DRAIN: begin
                // The device keeps ready high until it sees valid low; wait it
                // out so a stale ready is never taken as the next completion.
                if (!sysbus_i_io_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_DRAIN;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values independent of evaluation order between blocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_DRAIN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            bus_valid_q  <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
`ifdef IO_BRIDGE_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            bus_valid_q  <= bus_valid_d;
            bus_write_q  <= bus_write_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
`ifdef IO_BRIDGE_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign core_io_resp_valid = resp_valid_q;
    assign core_io_resp_data  = resp_data_q;
    assign core_io_resp_err   = resp_err_q;
    assign sysbus_o_io_valid  = bus_valid_q;
    assign sysbus_o_io_write  = bus_write_q;
    assign sysbus_o_io_addr   = bus_addr_q;
    assign sysbus_o_io_data   = bus_data_q;

endmodule

// File: tb/tb_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_io_bridge
//
// Self-checking bench for io_bridge. A device model answers the sysbus
// handshake; a queue-based reference model predicts every bus transaction and
// every core response from the address rules alone. One compare process checks
// the DUT outputs each cycle; directed sequences pin latencies with literals.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_io_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_io_req_valid = 1'b0;
    logic        core_io_req_ready;
    logic        core_io_req_write = 1'b0;
    logic [31:0] core_io_req_addr  = '0;
    logic [31:0] core_io_req_wdata = '0;
    logic        core_io_resp_valid;
    logic [31:0] core_io_resp_data;
    logic        core_io_resp_err;
    logic        sysbus_o_io_valid;
    logic        sysbus_o_io_write;
    logic [31:0] sysbus_o_io_addr;
    logic [31:0] sysbus_o_io_data;
    logic        sysbus_i_io_ready;
    logic [31:0] sysbus_i_io_data;

    always #5 clk = ~clk;

    io_bridge #(.DEPTH(2), .TIMEOUT(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .core_io_req_valid  (core_io_req_valid),
        .core_io_req_ready  (core_io_req_ready),
        .core_io_req_write  (core_io_req_write),
        .core_io_req_addr   (core_io_req_addr),
        .core_io_req_wdata  (core_io_req_wdata),
        .core_io_resp_valid (core_io_resp_valid),
        .core_io_resp_data  (core_io_resp_data),
        .core_io_resp_err   (core_io_resp_err),
        .sysbus_o_io_valid  (sysbus_o_io_valid),
        .sysbus_o_io_write  (sysbus_o_io_write),
        .sysbus_o_io_addr   (sysbus_o_io_addr),
        .sysbus_o_io_data   (sysbus_o_io_data),
        .sysbus_i_io_ready  (sysbus_i_io_ready),
        .sysbus_i_io_data   (sysbus_i_io_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- device model ----------------
    logic dev_ready = 1'b0;
    bit   dev_hold  = 1'b0;   // keep ready high regardless of valid
    bit   dev_never = 1'b0;   // never acknowledge
    int   dev_delay = 0;      // extra cycles before acknowledging
    int   dev_wait  = 0;

    function automatic logic [31:0] dev_rdata(input logic [31:0] a);
        if (a == 32'hfe00_0010) return 32'h0000_1234;
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
    endfunction

    always @(posedge clk) begin
        if (dev_hold) begin
            dev_ready <= 1'b1;
        end else if (!sysbus_o_io_valid) begin
            dev_ready <= 1'b0;
            dev_wait  <= 0;
        end else if (!dev_ready && !dev_never) begin
            if (dev_wait >= dev_delay) dev_ready <= 1'b1;
            else                       dev_wait  <= dev_wait + 1;
        end
    end

    assign sysbus_i_io_ready = dev_ready;
    assign sysbus_i_io_data  = dev_ready ? dev_rdata(sysbus_o_io_addr) : 32'hdead_beef;

    // ---------------- reference model ----------------
    typedef struct { logic err; logic [31:0] data; } resp_t;
    typedef struct { logic write; logic [31:0] addr; logic [31:0] data; } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    function automatic bit is_legal(input logic [31:0] a);
        return (a[31:24] == 8'hfe) && (a[1:0] == 2'b00);
    endfunction

    // ---------------- compare process ----------------
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        cap_write  = 1'b0;
    logic [31:0] cap_addr   = '0;
    logic [31:0] cap_data   = '0;
    logic [31:0] last_rdata = '0;
    logic        last_rerr  = 1'b0;
    int          resp_cyc_q[$];
    int          rise_cyc = -1;
    int          fall_cyc = -1;
    int          rise_count = 0;

    initial begin
        resp_t e;
        bus_t  b;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                resp_q.delete();
                bus_q.delete();
                check("rst_resp_valid", 32'(core_io_resp_valid), 0);
                check("rst_resp_data",  core_io_resp_data, 0);
                check("rst_resp_err",   32'(core_io_resp_err), 0);
                check("rst_bus_valid",  32'(sysbus_o_io_valid), 0);
                check("rst_bus_write",  32'(sysbus_o_io_write), 0);
                check("rst_bus_addr",   sysbus_o_io_addr, 0);
                check("rst_bus_data",   sysbus_o_io_data, 0);
                check("rst_req_ready",  32'(core_io_req_ready), 0);
                cap_write  = 1'b0;
                cap_addr   = '0;
                cap_data   = '0;
                last_rdata = '0;
                last_rerr  = 1'b0;
            end else begin
                if (core_io_resp_valid) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_resp", 1, 0);
                    end else begin
                        e = resp_q.pop_front();
                        check("resp_err",  32'(core_io_resp_err), 32'(e.err));
                        check("resp_data", core_io_resp_data, e.data);
                    end
                    last_rdata = core_io_resp_data;
                    last_rerr  = core_io_resp_err;
                    resp_cyc_q.push_back(cyc);
                end else begin
                    check("resp_data_hold", core_io_resp_data, last_rdata);
                    check("resp_err_hold",  32'(core_io_resp_err), 32'(last_rerr));
                end

                if (sysbus_o_io_valid && !prev_valid) begin
                    rise_count++;
                    rise_cyc = cyc;
                    check("issue_while_ready", 32'(prev_ready), 0);
                    if (bus_q.size() == 0) begin
                        check("unexpected_issue", 1, 0);
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_write", 32'(sysbus_o_io_write), 32'(b.write));
                        check("bus_addr",  sysbus_o_io_addr, b.addr);
                        check("bus_data",  sysbus_o_io_data, b.data);
                    end
                    cap_write = sysbus_o_io_write;
                    cap_addr  = sysbus_o_io_addr;
                    cap_data  = sysbus_o_io_data;
                end else begin
                    check("bus_write_stable", 32'(sysbus_o_io_write), 32'(cap_write));
                    check("bus_addr_stable",  sysbus_o_io_addr, cap_addr);
                    check("bus_data_stable",  sysbus_o_io_data, cap_data);
                end
                if (prev_valid && !sysbus_o_io_valid) fall_cyc = cyc;
            end
            prev_valid = sysbus_o_io_valid;
            prev_ready = sysbus_i_io_ready;
        end
    end

    // ---------------- driver ----------------
    // Presents one request; acc returns the edge index that accepts it.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit tmo, output int acc);
        int guard = 0;
        @(negedge clk);
        core_io_req_valid = 1'b1;
        core_io_req_write = w;
        core_io_req_addr  = a;
        core_io_req_wdata = d;
        while (!core_io_req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check("send_ready_timeout", 1, 0);
                core_io_req_valid = 1'b0;
                acc = -1;
                return;
            end
        end
        acc = cyc + 1;
        if (is_legal(a)) begin
            bus_q.push_back('{write: w, addr: a, data: d});
            if (tmo)    resp_q.push_back('{err: 1'b1, data: 32'h0});
            else if (w) resp_q.push_back('{err: 1'b0, data: 32'h0});
            else        resp_q.push_back('{err: 1'b0, data: dev_rdata(a)});
        end else begin
            resp_q.push_back('{err: 1'b1, data: 32'h0});
        end
        @(posedge clk);
        #1;
        core_io_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (resp_q.size() != 0 || bus_q.size() != 0 || sysbus_o_io_valid || dev_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                check("wait_idle_timeout", 1, 0);
                return;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc, acc_a, acc_b, acc_c, acc_d, acc1, acc2, n0, r0;
        logic [31:0] rnd, addr;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(core_io_req_ready), 1);
        repeat (2) @(negedge clk);

        // Store: valid high E1..E3, response at E3.
        send(1'b1, 32'hfe00_0000, 32'h0000_0041, 1'b0, acc);
        wait_idle();
        check("store_rise_lat", 32'(rise_cyc - acc), 1);
        check("store_fall_lat", 32'(fall_cyc - acc), 3);
        check("store_resp_lat", 32'(resp_cyc_q[$] - acc), 3);
        check("store_resp_err", 32'(last_rerr), 0);
        check("store_resp_data", last_rdata, 32'h0);

        // Load.
        send(1'b0, 32'hfe00_0010, 32'h0, 1'b0, acc);
        wait_idle();
        check("load_resp_lat", 32'(resp_cyc_q[$] - acc), 3);
        check("load_resp_data", last_rdata, 32'h0000_1234);
        check("load_resp_err", 32'(last_rerr), 0);

        // Illegal addresses: no bus traffic, response one cycle after pop.
        r0 = rise_count;
        n0 = resp_cyc_q.size();
        send(1'b0, 32'h8000_0000, 32'h0, 1'b0, acc1);
        send(1'b1, 32'hfe00_0002, 32'h1234_5678, 1'b0, acc2);
        wait_idle();
        check("illegal_no_issue", 32'(rise_count - r0), 0);
        check("illegal_resp_count", 32'(resp_cyc_q.size() - n0), 2);
        check("illegal0_lat", 32'(resp_cyc_q[n0] - acc1), 1);
        check("illegal1_lat", 32'(resp_cyc_q[n0 + 1] - acc2), 1);
        check("illegal_err", 32'(last_rerr), 1);

        // Backpressure: four back-to-back pushes into a 2-deep FIFO.
        n0 = resp_cyc_q.size();
        send(1'b1, 32'hfe00_0100, 32'haaaa_0001, 1'b0, acc_a);
        send(1'b0, 32'hfe00_0104, 32'h0,         1'b0, acc_b);
        send(1'b1, 32'hfe00_0108, 32'haaaa_0003, 1'b0, acc_c);
        send(1'b0, 32'hfe00_010c, 32'h0,         1'b0, acc_d);
        wait_idle();
        check("bp_acc_b", 32'(acc_b - acc_a), 1);
        check("bp_acc_c", 32'(acc_c - acc_a), 2);
        check("bp_acc_d", 32'(acc_d - acc_a), 7);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_resp%0d_cyc", i), 32'(resp_cyc_q[n0 + i] - acc_a), 32'(3 + 5 * i));

        // Reset in REQ while the device keeps ready high.
        send(1'b0, 32'hfe00_0020, 32'h0, 1'b0, acc);
        repeat (3) @(negedge clk);
        check("mid_valid", 32'(sysbus_o_io_valid), 1);
        check("mid_ready", 32'(sysbus_i_io_ready), 1);
        rst_n    = 1'b0;
        dev_hold = 1'b1;
        r0 = rise_count;
        n0 = resp_cyc_q.size();
        @(negedge clk);
        rst_n = 1'b1;
        fork
            begin @(negedge clk); dev_hold = 1'b0; end
        join_none
        send(1'b1, 32'hfe00_0024, 32'h0000_00bb, 1'b0, acc);
        wait_idle();
        check("rst_reissue_lat", 32'(rise_cyc - acc), 2);
        check("rst_one_issue", 32'(rise_count - r0), 1);
        check("rst_one_resp", 32'(resp_cyc_q.size() - n0), 1);

`ifdef IO_BRIDGE_TIMEOUT_EN
        // Device never answers: abort 8 cycles after valid rose.
        dev_never = 1'b1;
        n0 = resp_cyc_q.size();
        send(1'b1, 32'hfe00_0040, 32'h0000_0007, 1'b1, acc);
        wait_idle();
        dev_never = 1'b0;
        check("tmo_resp_lat", 32'(resp_cyc_q[n0] - rise_cyc), 8);
        check("tmo_fall", 32'(fall_cyc - rise_cyc), 8);
        check("tmo_err", 32'(last_rerr), 1);
        check("tmo_data", last_rdata, 32'h0);
`endif

        // Randomized mix of legal, misaligned and out-of-window requests.
        for (int i = 0; i < 80; i++) begin
            rnd  = $urandom();
            addr = $urandom();
            case ($urandom_range(0, 9))
                0:       addr[31:24] = 8'h80;
                1:       begin addr[31:24] = 8'hfe; addr[1:0] = 2'(1 + $urandom_range(0, 2)); end
                default: begin addr[31:24] = 8'hfe; addr[1:0] = 2'b00; end
            endcase
            dev_delay = $urandom_range(0, 2);
            send(rnd[0], addr, $urandom(), 1'b0, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        check("rand_model_drained", 32'(resp_q.size() + bus_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
